// File: rtl/locals_stack.sv
// Typed operand stack with cached top-of-stack and frame-relative local access.
// Optional LOCALS_TYPECHECK_EN: SET/TEE trap on a type mismatch with the target local.
module locals_stack #(
    parameter int unsigned WIDTH       = 64,
    parameter int unsigned STACK_DEPTH = 7,
    parameter int unsigned LOCAL_W     = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   op_valid,
    output logic                   op_ready,
    input  logic [2:0]             op_code,
    input  logic [LOCAL_W-1:0]     op_index,
    input  logic [WIDTH-1:0]       push_data,
    input  logic [1:0]             push_type,
    output logic [WIDTH-1:0]       top_data,
    output logic [1:0]             top_type,
    output logic                   empty,
    output logic [STACK_DEPTH:0]   sp,
    output logic [STACK_DEPTH:0]   fp,
    output logic [3:0]             trap
);

    localparam int unsigned SP_W  = STACK_DEPTH + 1;
    localparam int unsigned DEPTH = 2 ** STACK_DEPTH;
    localparam int unsigned AW    = ((SP_W > LOCAL_W) ? SP_W : LOCAL_W) + 2;

    localparam logic [SP_W-1:0] CAP = SP_W'(DEPTH);

    localparam logic [2:0] OP_PUSH  = 3'd1;
    localparam logic [2:0] OP_POP   = 3'd2;
    localparam logic [2:0] OP_GET   = 3'd3;
    localparam logic [2:0] OP_SET   = 3'd4;
    localparam logic [2:0] OP_TEE   = 3'd5;
    localparam logic [2:0] OP_FRAME = 3'd6;

    localparam logic [3:0] TRAP_NONE  = 4'd0;
    localparam logic [3:0] TRAP_OVER  = 4'd1;
    localparam logic [3:0] TRAP_UNDER = 4'd2;
    localparam logic [3:0] TRAP_LOCAL = 4'd3;
`ifdef LOCALS_TYPECHECK_EN
    localparam logic [3:0] TRAP_TYPE  = 4'd4;
`endif

    typedef struct packed {
        logic [1:0]       vtype;
        logic [WIDTH-1:0] data;
    } entry_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_REFILL
    } state_e;

    // Entries 0..sp-2 live in RAM; entry sp-1 is cached in top_q.
    entry_t ram [DEPTH];

    state_e            state_q, state_d;
    logic [SP_W-1:0]   sp_q, sp_d;
    logic [SP_W-1:0]   fp_q, fp_d;
    logic [SP_W-1:0]   addr_q, addr_d;
    entry_t            top_q, top_d;
    logic [3:0]        trap_q, trap_d;
    logic              ready_q, ready_d;
    logic              empty_q, empty_d;

    logic                   we_c;
    logic [STACK_DEPTH-1:0] waddr_c;
    entry_t                 wdata_c;

    logic [AW-1:0]     addr_w_c;
    logic [SP_W-1:0]   addr_c;
    logic [SP_W-1:0]   sp_m1_c;
    logic              addr_ok_c;
    logic              addr_below_top_c;
    logic              at_top_c;
    logic              idx_gt_sp_c;
    logic              type_bad_c;

    // Local address computed wide so fp+index overflow simply fails the bound check.
    assign addr_w_c         = AW'(fp_q) + AW'(op_index);
    assign addr_c           = SP_W'(addr_w_c);
    assign sp_m1_c          = sp_q - SP_W'(1);
    assign addr_ok_c        = addr_w_c < AW'(sp_q);
    assign addr_below_top_c = (addr_w_c + AW'(1)) < AW'(sp_q);
    assign at_top_c         = addr_c == sp_m1_c;
    assign idx_gt_sp_c      = AW'(op_index) > AW'(sp_q);

`ifdef LOCALS_TYPECHECK_EN
    entry_t local_rd_c;
    assign local_rd_c = ram[addr_c[STACK_DEPTH-1:0]];
    assign type_bad_c = !at_top_c && (local_rd_c.vtype != top_q.vtype);
`else
    assign type_bad_c = 1'b0;
`endif

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            sp_q    <= '0;
            fp_q    <= '0;
            addr_q  <= '0;
            top_q   <= '0;
            trap_q  <= TRAP_NONE;
            ready_q <= 1'b1;
            empty_q <= 1'b1;
        end else begin
            state_q <= state_d;
            sp_q    <= sp_d;
            fp_q    <= fp_d;
            addr_q  <= addr_d;
            top_q   <= top_d;
            trap_q  <= trap_d;
            ready_q <= ready_d;
            empty_q <= empty_d;
        end
    end

    // Stack RAM write port; contents are not reset.
    always_ff @(posedge clk) begin
        if (we_c) begin
            ram[waddr_c] <= wdata_c;
        end
    end

    // Next-state, datapath updates and RAM write control.
    always_comb begin
        state_d = state_q;
        sp_d    = sp_q;
        fp_d    = fp_q;
        addr_d  = addr_q;
        top_d   = top_q;
        trap_d  = trap_q;
        we_c    = 1'b0;
        waddr_c = sp_m1_c[STACK_DEPTH-1:0];
        wdata_c = top_q;

        case (state_q)
            S_IDLE: begin
                if (op_valid && ready_q) begin
                    case (op_code)
                        OP_PUSH: begin
                            if (sp_q == CAP) begin
                                trap_d = TRAP_OVER;
                            end else begin
                                we_c        = sp_q != '0;
                                top_d.data  = push_data;
                                top_d.vtype = push_type;
                                sp_d        = sp_q + SP_W'(1);
                            end
                        end
                        OP_POP: begin
                            if (sp_q == '0) begin
                                trap_d = TRAP_UNDER;
                            end else begin
                                sp_d = sp_m1_c;
                                if (sp_q == SP_W'(1)) begin
                                    top_d = '0;
                                end else begin
                                    addr_d  = sp_q - SP_W'(2);
                                    state_d = S_REFILL;
                                end
                            end
                        end
                        OP_GET: begin
                            if (!addr_ok_c) begin
                                trap_d = TRAP_LOCAL;
                            end else if (sp_q == CAP) begin
                                trap_d = TRAP_OVER;
                            end else begin
                                addr_d  = addr_c;
                                state_d = S_READ;
                            end
                        end
                        OP_SET: begin
                            if (sp_q == '0) begin
                                trap_d = TRAP_UNDER;
                            end else if (!addr_below_top_c) begin
                                trap_d = TRAP_LOCAL;
                            end else if (type_bad_c) begin
`ifdef LOCALS_TYPECHECK_EN
                                trap_d = TRAP_TYPE;
`endif
                            end else begin
                                we_c    = 1'b1;
                                waddr_c = addr_c[STACK_DEPTH-1:0];
                                sp_d    = sp_m1_c;
                                addr_d  = sp_q - SP_W'(2);
                                state_d = S_REFILL;
                            end
                        end
                        OP_TEE: begin
                            if (!addr_ok_c) begin
                                trap_d = TRAP_LOCAL;
                            end else if (type_bad_c) begin
`ifdef LOCALS_TYPECHECK_EN
                                trap_d = TRAP_TYPE;
`endif
                            end else if (!at_top_c) begin
                                we_c    = 1'b1;
                                waddr_c = addr_c[STACK_DEPTH-1:0];
                            end
                        end
                        OP_FRAME: begin
                            if (idx_gt_sp_c) begin
                                trap_d = TRAP_UNDER;
                            end else begin
                                fp_d = sp_q - SP_W'(op_index);
                            end
                        end
                        default: ;
                    endcase
                end
            end
            S_READ: begin
                // Local at sp-1 is the cached top, not yet in RAM.
                we_c  = 1'b1;
                top_d = (addr_q == sp_m1_c) ? top_q : ram[addr_q[STACK_DEPTH-1:0]];
                sp_d  = sp_q + SP_W'(1);
                state_d = S_IDLE;
            end
            S_REFILL: begin
                top_d   = ram[addr_q[STACK_DEPTH-1:0]];
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        ready_d = (state_d == S_IDLE) && (trap_d == TRAP_NONE);
        empty_d = sp_d == '0;
    end

    assign op_ready = ready_q;
    assign top_data = top_q.data;
    assign top_type = top_q.vtype;
    assign empty    = empty_q;
    assign sp       = sp_q;
    assign fp       = fp_q;
    assign trap     = trap_q;

endmodule

// File: tb/tb_locals_stack.sv
// Table-driven bench for locals_stack with a queue scoreboard of expected results.
module tb_locals_stack;

    localparam int unsigned WIDTH       = 64;
    localparam int unsigned STACK_DEPTH = 7;
    localparam int unsigned LOCAL_W     = 4;

    localparam logic [2:0] NOP = 3'd0, PUSH = 3'd1, POP = 3'd2, GET = 3'd3,
                           SET = 3'd4, TEE = 3'd5, FRAME = 3'd6;

    logic                 clk;
    logic                 reset;
    logic                 op_valid;
    logic                 op_ready;
    logic [2:0]           op_code;
    logic [LOCAL_W-1:0]   op_index;
    logic [WIDTH-1:0]     push_data;
    logic [1:0]           push_type;
    logic [WIDTH-1:0]     top_data;
    logic [1:0]           top_type;
    logic                 empty;
    logic [STACK_DEPTH:0] sp;
    logic [STACK_DEPTH:0] fp;
    logic [3:0]           trap;

    locals_stack #(.WIDTH(WIDTH), .STACK_DEPTH(STACK_DEPTH), .LOCAL_W(LOCAL_W)) dut (
        .clk(clk), .reset(reset), .op_valid(op_valid), .op_ready(op_ready),
        .op_code(op_code), .op_index(op_index), .push_data(push_data),
        .push_type(push_type), .top_data(top_data), .top_type(top_type),
        .empty(empty), .sp(sp), .fp(fp), .trap(trap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          rst;
        logic [2:0]  op;
        logic [3:0]  idx;
        logic [63:0] data;
        logic [1:0]  ty;
        logic [63:0] e_top;
        logic [1:0]  e_ty;
        int          e_sp;
        int          e_fp;
        int          e_trap;
        int          e_wait;
    } vec_t;

    vec_t vecs[$];
    vec_t sb_q[$];
    int checks   = 0;
    int failures = 0;

    function automatic vec_t mk(input logic [2:0] op, input int idx, input logic [63:0] data,
                                input int ty, input logic [63:0] e_top, input int e_ty,
                                input int e_sp, input int e_fp, input int e_trap, input int e_wait);
        vec_t v;
        v.rst = 1'b0; v.op = op; v.idx = 4'(idx); v.data = data; v.ty = 2'(ty);
        v.e_top = e_top; v.e_ty = 2'(e_ty); v.e_sp = e_sp; v.e_fp = e_fp;
        v.e_trap = e_trap; v.e_wait = e_wait;
        return v;
    endfunction

    function automatic vec_t mk_rst();
        vec_t v;
        v = mk(NOP, 0, 64'd0, 0, 64'd0, 0, 0, 0, 0, 0);
        v.rst = 1'b1;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic compare(input vec_t e, input int waits);
        chk("top_data", top_data, e.e_top);
        chk("top_type", 64'(top_type), 64'(e.e_ty));
        chk("sp", 64'(sp), 64'(e.e_sp));
        chk("fp", 64'(fp), 64'(e.e_fp));
        chk("trap", 64'(trap), 64'(e.e_trap));
        chk("empty", 64'(empty), 64'(e.e_sp == 0));
        chk("op_ready", 64'(op_ready), 64'(e.e_trap == 0));
        chk("busy_cycles", 64'(waits), 64'(e.e_wait));
    endtask

    // Starts and ends at a falling edge, where outputs are sampled.
    task automatic run(input vec_t v);
        vec_t e;
        int   waits;
        if (v.rst) begin
            reset    = 1'b1;
            op_valid = 1'b0;
            sb_q.push_back(v);
            repeat (2) @(posedge clk);
            @(negedge clk);
            reset = 1'b0;
            e = sb_q.pop_front();
            compare(e, 0);
            return;
        end
        chk("ready_before_op", 64'(op_ready), 64'd1);
        op_valid  = 1'b1;
        op_code   = v.op;
        op_index  = v.idx;
        push_data = v.data;
        push_type = v.ty;
        sb_q.push_back(v);
        @(posedge clk);
        #1 op_valid = 1'b0;
        @(negedge clk);
        waits = 0;
        while (!op_ready && trap == 4'd0 && waits < 16) begin
            waits++;
            @(negedge clk);
        end
        e = sb_q.pop_front();
        compare(e, waits);
    endtask

    initial begin
        reset = 1'b1; op_valid = 1'b0; op_code = NOP; op_index = '0;
        push_data = '0; push_type = '0;
        @(negedge clk);

        // Basic push.
        vecs.push_back(mk_rst());
        vecs.push_back(mk(PUSH, 0, 64'd5, 0, 64'd5, 0, 1, 0, 0, 0));
        vecs.push_back(mk(PUSH, 0, 64'd7, 0, 64'd7, 0, 2, 0, 0, 0));
        // Frame, locals, refill and pop-to-empty.
        vecs.push_back(mk_rst());
        vecs.push_back(mk(PUSH,  0, 64'd1, 1, 64'd1, 1, 1, 0, 0, 0));
        vecs.push_back(mk(PUSH,  0, 64'd2, 1, 64'd2, 1, 2, 0, 0, 0));
        vecs.push_back(mk(PUSH,  0, 64'd3, 1, 64'd3, 1, 3, 0, 0, 0));
        vecs.push_back(mk(FRAME, 3, 64'd0, 0, 64'd3, 1, 3, 0, 0, 0));
        vecs.push_back(mk(GET,   1, 64'd0, 0, 64'd2, 1, 4, 0, 0, 1));
        vecs.push_back(mk(PUSH,  0, 64'd4, 1, 64'd4, 1, 5, 0, 0, 0));
        vecs.push_back(mk(SET,   0, 64'd0, 0, 64'd2, 1, 4, 0, 0, 1));
        vecs.push_back(mk(GET,   0, 64'd0, 0, 64'd4, 1, 5, 0, 0, 1));
        vecs.push_back(mk(POP,   0, 64'd0, 0, 64'd2, 1, 4, 0, 0, 1));
        vecs.push_back(mk(TEE,   3, 64'd0, 0, 64'd2, 1, 4, 0, 0, 0));
        vecs.push_back(mk(GET,   2, 64'd0, 0, 64'd3, 1, 5, 0, 0, 1));
        vecs.push_back(mk(POP,   0, 64'd0, 0, 64'd2, 1, 4, 0, 0, 1));
        vecs.push_back(mk(POP,   0, 64'd0, 0, 64'd3, 1, 3, 0, 0, 1));
        vecs.push_back(mk(POP,   0, 64'd0, 0, 64'd2, 1, 2, 0, 0, 1));
        vecs.push_back(mk(POP,   0, 64'd0, 0, 64'd4, 1, 1, 0, 0, 1));
        vecs.push_back(mk(POP,   0, 64'd0, 0, 64'd0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(PUSH,  0, 64'd9, 0, 64'd9, 0, 1, 0, 0, 0));
        vecs.push_back(mk(FRAME, 0, 64'd0, 0, 64'd9, 0, 1, 1, 0, 0));
        vecs.push_back(mk(GET,   0, 64'd0, 0, 64'd9, 0, 1, 1, 3, 0));
        // Underflow and out-of-range local.
        vecs.push_back(mk_rst());
        vecs.push_back(mk(POP,   0, 64'd0, 0, 64'd0, 0, 0, 0, 2, 0));
        vecs.push_back(mk_rst());
        vecs.push_back(mk(PUSH,  0, 64'd1, 0, 64'd1, 0, 1, 0, 0, 0));
        vecs.push_back(mk(PUSH,  0, 64'd2, 0, 64'd2, 0, 2, 0, 0, 0));
        vecs.push_back(mk(GET,   2, 64'd0, 0, 64'd2, 0, 2, 0, 3, 0));
        // Non-zero frame base, top bypass, oversized frame.
        vecs.push_back(mk_rst());
        vecs.push_back(mk(PUSH,  0, 64'd5, 0, 64'd5, 0, 1, 0, 0, 0));
        vecs.push_back(mk(PUSH,  0, 64'd6, 0, 64'd6, 0, 2, 0, 0, 0));
        vecs.push_back(mk(PUSH,  0, 64'd7, 0, 64'd7, 0, 3, 0, 0, 0));
        vecs.push_back(mk(FRAME, 1, 64'd0, 0, 64'd7, 0, 3, 2, 0, 0));
        vecs.push_back(mk(GET,   0, 64'd0, 0, 64'd7, 0, 4, 2, 0, 1));
        vecs.push_back(mk(FRAME, 5, 64'd0, 0, 64'd7, 0, 4, 2, 2, 0));
        // SET/TEE bounds.
        vecs.push_back(mk_rst());
        vecs.push_back(mk(SET,   0, 64'd0, 0, 64'd0, 0, 0, 0, 2, 0));
        vecs.push_back(mk_rst());
        vecs.push_back(mk(PUSH,  0, 64'd1, 0, 64'd1, 0, 1, 0, 0, 0));
        vecs.push_back(mk(SET,   0, 64'd0, 0, 64'd1, 0, 1, 0, 3, 0));
        vecs.push_back(mk_rst());
        vecs.push_back(mk(PUSH,  0, 64'd1, 0, 64'd1, 0, 1, 0, 0, 0));
        vecs.push_back(mk(TEE,   1, 64'd0, 0, 64'd1, 0, 1, 0, 3, 0));
        // TEE type handling.
        vecs.push_back(mk_rst());
        vecs.push_back(mk(PUSH,  0, 64'h11, 0, 64'h11, 0, 1, 0, 0, 0));
        vecs.push_back(mk(PUSH,  0, 64'h44, 0, 64'h44, 0, 2, 0, 0, 0));
        vecs.push_back(mk(TEE,   0, 64'd0,  0, 64'h44, 0, 2, 0, 0, 0));
        vecs.push_back(mk(POP,   0, 64'd0,  0, 64'h44, 0, 1, 0, 0, 1));
        vecs.push_back(mk(PUSH,  0, 64'h22, 3, 64'h22, 3, 2, 0, 0, 0));
`ifdef LOCALS_TYPECHECK_EN
        vecs.push_back(mk(TEE,   0, 64'd0,  0, 64'h22, 3, 2, 0, 4, 0));
`else
        vecs.push_back(mk(TEE,   0, 64'd0,  0, 64'h22, 3, 2, 0, 0, 0));
        vecs.push_back(mk(POP,   0, 64'd0,  0, 64'h22, 3, 1, 0, 0, 1));
`endif

        foreach (vecs[i]) run(vecs[i]);

        // Fill to capacity, then overflow; trap must hold until reset.
        run(mk_rst());
        for (int i = 0; i < (2 ** STACK_DEPTH); i++) begin
            run(mk(PUSH, 0, 64'(i) + 64'h100, i % 4, 64'(i) + 64'h100, i % 4, i + 1, 0, 0, 0));
        end
        run(mk(PUSH, 0, 64'hdead, 0, 64'h17f, 3, 2 ** STACK_DEPTH, 0, 1, 0));
        repeat (3) @(negedge clk);
        chk("ready_held_low", 64'(op_ready), 64'd0);
        chk("trap_sticky", 64'(trap), 64'd1);
        run(mk_rst());

        // Reset during a refill aborts it.
        run(mk(PUSH, 0, 64'd1, 0, 64'd1, 0, 1, 0, 0, 0));
        run(mk(PUSH, 0, 64'd2, 0, 64'd2, 0, 2, 0, 0, 0));
        op_valid = 1'b1; op_code = POP; op_index = '0;
        @(posedge clk);
        #1 op_valid = 1'b0; reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("abort_sp", 64'(sp), 64'd0);
        chk("abort_top", top_data, 64'd0);
        chk("abort_ready", 64'(op_ready), 64'd1);
        chk("abort_empty", 64'(empty), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
